// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with shadow/active double buffering and frame-aligned commit.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [6:0]            wr_data,
  input  logic                  commit,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [NUM_DIGITS-1:0] seg_com,
  output logic [6:0]            seg7,
  output logic                  busy,
  output logic                  commit_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [6:0] Dash = 7'b000_0001;

  logic                  run_q, run_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic [6:0]            seg_q, seg_d;
  logic [6:0]            shadow_q [NUM_DIGITS];
  logic [6:0]            shadow_d [NUM_DIGITS];
  logic [6:0]            active_q [NUM_DIGITS];
  logic [6:0]            active_d [NUM_DIGITS];

  logic            load;
  logic            boundary;
  logic            copy;
  logic [IdxW-1:0] waddr;
  logic [IdxW-1:0] rd_idx;
  logic            blank;

`ifdef SEG_BLINK_EN
  localparam int unsigned BfW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BfW-1:0] BfLast = BfW'(BLINK_FRAMES - 1);

  logic [BfW-1:0] frame_q, frame_d;
  logic           phase_q, phase_d;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
`endif

  // Scan timing: the first edge out of reset only lights idx 0, then the divider runs.
  always_comb begin
    run_d    = 1'b1;
    div_d    = div_q;
    idx_d    = idx_q;
    load     = 1'b0;
    boundary = 1'b0;
    if (!run_q) begin
      load = 1'b1;
    end else if (div_q == DivLast) begin
      div_d = '0;
      load  = 1'b1;
      if (idx_q == IdxLast) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  // Copy samples the pre-write shadow; a same-edge commit re-arms for the next frame.
  always_comb begin
    copy      = boundary & pending_q;
    done_d    = copy;
    pending_d = copy ? commit : (pending_q | commit);
    waddr     = wr_addr[IdxW-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = copy ? shadow_q[i] : active_q[i];
    end
    if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
      shadow_d[waddr] = wr_data;
    end
  end

`ifdef SEG_BLINK_EN
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (boundary) begin
      if (frame_q == BfLast) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + BfW'(1);
      end
    end
  end
`endif

  // seg_com bit 0 is the rightmost digit, which holds the last buffer entry.
  always_comb begin
    rd_idx = IdxLast - idx_d;
`ifdef SEG_BLINK_EN
    blank  = ~phase_d & blink_mask[rd_idx];
`else
    blank  = 1'b0;
`endif
    com_d  = com_q;
    seg_d  = seg_q;
    if (load) begin
      com_d = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = blank ? 7'b000_0000 : active_d[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      div_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      com_q     <= '1;
      seg_q     <= 7'b000_0000;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= Dash;
        active_q[i] <= Dash;
      end
`ifdef SEG_BLINK_EN
      frame_q   <= '0;
      phase_q   <= 1'b1;
`endif
    end else begin
      run_q     <= run_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      com_q     <= com_d;
      seg_q     <= seg_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
`ifdef SEG_BLINK_EN
      frame_q   <= frame_d;
      phase_q   <= phase_d;
`endif
    end
  end

  assign seg_com     = com_q;
  assign seg7        = seg_q;
  assign busy        = pending_q;
  assign commit_done = done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised bench for seg_scan_display: slot/frame arithmetic model plus directed literal checks.
module tb_seg_scan_display;

  localparam int N  = 8;
  localparam int D  = 3;
  localparam int BF = 2;
  localparam logic [6:0] Dash = 7'b000_0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [6:0]   wr_data = '0;
  logic         commit = 1'b0;
  logic [N-1:0] blink_mask = '0;
  logic [N-1:0] seg_com;
  logic [6:0]   seg7;
  logic         busy;
  logic         commit_done;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (D),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .blink_mask (blink_mask),
    .seg_com    (seg_com),
    .seg7       (seg7),
    .busy       (busy),
    .commit_done(commit_done)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: buffers, pending flag, and the count of edges since reset released.
  logic [6:0]   m_shadow [N];
  logic [6:0]   m_active [N];
  bit           m_pending;
  int           m_edges;
  logic [N-1:0] x_com;
  logic [6:0]   x_seg;
  bit           x_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slot s is lit from edge 1+s*D; frame f = s/N; a boundary is the start of slot k*N, k>0.
  task automatic model_step();
    int           s, k;
    bit           slot_start, bnd;
    logic [N-1:0] one;
    one = 1;
    if (rst) begin
      m_edges   = 0;
      m_pending = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = Dash;
        m_active[i] = Dash;
      end
      x_com  = '1;
      x_seg  = '0;
      x_done = 1'b0;
    end else begin
      m_edges++;
      slot_start = ((m_edges - 1) % D) == 0;
      s          = (m_edges - 1) / D;
      bnd        = slot_start && (s % N == 0) && (s > 0);
      x_done     = bnd && m_pending;
      if (x_done) begin
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      end
      if (wr_en && (int'(wr_addr) < N)) m_shadow[wr_addr] = wr_data;
      m_pending = x_done ? commit : (m_pending || commit);
      if (slot_start) begin
        k     = s % N;
        x_com = ~(one << k);
        x_seg = m_active[N-1-k];
`ifdef SEG_BLINK_EN
        if ((((s / N) / BF) % 2 == 1) && blink_mask[N-1-k]) x_seg = 7'b000_0000;
`endif
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("seg_com", 32'(seg_com), 32'(x_com));
        check("seg7", 32'(seg7), 32'(x_seg));
        check("busy", 32'(busy), 32'(m_pending));
        check("commit_done", 32'(commit_done), 32'(x_done));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < limit) begin
      tick(1);
      n++;
      if (commit_done) seen = 1'b1;
    end
    check("commit_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_com(input logic [N-1:0] want, input int limit);
    int n;
    n = 0;
    while (seg_com !== want && n < limit) begin
      tick(1);
      n++;
    end
    check("seg_com_wait_timeout", 32'(seg_com), 32'(want));
  endtask

  logic [7:0] com_seq [8];
  logic [6:0] blink_exp;

  initial begin
    com_seq[0] = 8'hFE; com_seq[1] = 8'hFD; com_seq[2] = 8'hFB; com_seq[3] = 8'hF7;
    com_seq[4] = 8'hEF; com_seq[5] = 8'hDF; com_seq[6] = 8'hBF; com_seq[7] = 8'h7F;

    // Reset state
    rst = 1'b1;
    tick(3);
    chk_en = 1'b1;
    check("rst_seg_com", 32'(seg_com), 32'hFF);
    check("rst_seg7", 32'(seg7), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(commit_done), 32'd0);
    rst = 1'b0;

    // Free-running scan, first digit lit on the first edge after reset
    tick(1);
    for (int s = 0; s < 9; s++) begin
      check("scan_com", 32'(seg_com), 32'(com_seq[s % 8]));
      check("scan_seg7", 32'(seg7), 32'(Dash));
      tick(D);
    end

    // Mid-frame writes and commit
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'b111_0111;
    tick(1);
    wr_addr = 4'd7; wr_data = 7'b011_0011;
    tick(1);
    wr_en = 1'b0; commit = 1'b1;
    tick(1);
    commit = 1'b0;
    check("commit_busy", 32'(busy), 32'd1);
    check("commit_active_unchanged", 32'(seg7), 32'(Dash));
    wait_done(40);
    check("copy_com_right", 32'(seg_com), 32'hFE);
    check("copy_seg_right", 32'(seg7), 32'b011_0011);
    check("copy_busy_clear", 32'(busy), 32'd0);
    tick(7 * D);
    check("copy_com_left", 32'(seg_com), 32'h7F);
    check("copy_seg_left", 32'(seg7), 32'b111_0111);

    // Out-of-range write is dropped, commit still completes once
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 7'b111_1111;
    tick(1);
    wr_en = 1'b0; commit = 1'b1;
    tick(1);
    commit = 1'b0;
    wait_done(40);
    check("oob_seg_right", 32'(seg7), 32'b011_0011);
    tick(1);
    check("oob_done_single", 32'(commit_done), 32'd0);

    // Commit on the boundary edge, then reset before it can land
    wait_com(8'h7F, 40);
    tick(D - 1);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    check("bnd_commit_busy", 32'(busy), 32'd1);
    check("bnd_commit_no_done", 32'(commit_done), 32'd0);
    check("bnd_commit_com", 32'(seg_com), 32'hFE);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_com", 32'(seg_com), 32'hFF);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < N; k++) begin
      check("post_rst_dash", 32'(seg7), 32'(Dash));
      check("post_rst_com", 32'(seg_com), 32'(com_seq[k]));
      tick(D);
    end

    // Blink on buffer 0 (leftmost): frames 2-3 blank when compiled in
`ifdef SEG_BLINK_EN
    blink_exp = 7'b000_0000;
`else
    blink_exp = Dash;
`endif
    rst = 1'b1;
    blink_mask = 8'h01;
    tick(2);
    rst = 1'b0;
    tick(1);
    tick(7 * D);
    check("blink_f0_com", 32'(seg_com), 32'h7F);
    check("blink_f0_seg", 32'(seg7), 32'(Dash));
    tick(16 * D);
    check("blink_f2_com", 32'(seg_com), 32'h7F);
    check("blink_f2_seg", 32'(seg7), 32'(blink_exp));
    tick(D);
    check("blink_f3_other", 32'(seg7), 32'(Dash));
    tick(15 * D);
    check("blink_f4_seg", 32'(seg7), 32'(Dash));

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom % 3) == 0;
      wr_addr = 4'($urandom % 16);
      wr_data = 7'($urandom);
      commit  = ($urandom % 20) == 0;
      if ($urandom % 50 == 0) blink_mask = N'($urandom);
      rst     = ($urandom % 400) == 0;
      tick(1);
    end
    rst = 1'b0; wr_en = 1'b0; commit = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
